// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bundle: instruction memory port, redirect port,
// and the decode-side valid/ready head port.
interface fetch_queue_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_req;
  logic [INSTR_WIDTH-1:0] imem_instr;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   out_valid;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic                   out_ready;
  logic [CW-1:0]          count;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready,
    output count
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready,
    input  count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// LEGv8 fetch front end: PC generator feeding a DEPTH-entry
// prefetch queue of {pc, instr} pairs drained by decode.
module fetch_queue_unit #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned PC_STEP     = 4
) (
  input logic CLOCK,
  input logic RESET,
  fetch_queue_unit_if.master fq
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } qEntry_t;

  qEntry_t               qMem [DEPTH];
  logic [ADDR_WIDTH-1:0] fetchPc;
  logic [PW-1:0]         rdPtr;
  logic [PW-1:0]         wrPtr;
  logic [CW-1:0]         occ;

  logic notFull;
  logic headValid;
  logic doPush;
  logic doPop;
  logic flush;

  assign notFull   = occ < CW'(DEPTH);
  assign headValid = occ != '0;
  assign flush     = fq.redirect_valid;

  // Full-check uses occupancy only; a same-cycle pop never frees a slot.
  assign doPush = RESET && notFull && !flush;
  assign doPop  = headValid && fq.out_ready;

  assign fq.imem_addr = fetchPc;
  assign fq.imem_req  = doPush;
  assign fq.out_valid = headValid;
  assign fq.out_pc    = headValid ? qMem[rdPtr].pc : '0;
  assign fq.out_instr = headValid ? qMem[rdPtr].instr : '0;
  assign fq.count     = occ;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      fetchPc <= RESET_PC;
    end else if (flush) begin
      fetchPc <= fq.redirect_pc;
    end else if (doPush) begin
      fetchPc <= fetchPc + ADDR_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        qMem[i] <= '0;
      end
    end else if (doPush) begin
      qMem[wrPtr] <= '{pc: fetchPc, instr: fq.imem_instr};
    end
  end

  // A head handshake coinciding with a redirect is simply dropped
  // with the rest of the queue: decode already consumed it.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rdPtr <= '0;
      wrPtr <= '0;
      occ   <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      occ   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit against a queue-based
// reference model, plus directed literal scenarios.
module tb_fetch_queue_unit;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)
  ) ifc ();

  fetch_queue_unit #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH),
    .RESET_PC('0), .PC_STEP(4)
  ) dut (
    .CLOCK(clk),
    .RESET(rstn),
    .fq(ifc)
  );

  function automatic logic [IW-1:0] memf(logic [AW-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hDEAD_BEEF;
  endfunction

  always_comb ifc.imem_instr = memf(ifc.imem_addr);

  ent_t mq[$];
  logic [AW-1:0] mpc;
  logic [AW-1:0] acc[$];
  int nA = 0;
  int nF = 0;

  task automatic cmp(string n, logic [AW-1:0] act, logic [AW-1:0] exp);
    nA++;
    if (act !== exp) begin
      nF++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic req;
    logic [AW-1:0] hp;
    logic [AW-1:0] hi;
    req = rstn && (mq.size() < DEPTH) && !ifc.redirect_valid;
    hp = (mq.size() != 0) ? mq[0].pc : '0;
    hi = (mq.size() != 0) ? AW'(mq[0].ins) : '0;
    cmp("out_valid", AW'(ifc.out_valid), AW'(mq.size() != 0));
    cmp("out_pc", ifc.out_pc, hp);
    cmp("out_instr", AW'(ifc.out_instr), hi);
    cmp("count", AW'(ifc.count), AW'(mq.size()));
    cmp("imem_addr", ifc.imem_addr, mpc);
    cmp("imem_req", AW'(ifc.imem_req), AW'(req));
  endtask

  task automatic modelStep(bit rdy, bit rd, logic [AW-1:0] rp);
    bit req;
    bit pop;
    ent_t e;
    req = (mq.size() < DEPTH) && !rd;
    pop = (mq.size() != 0) && rdy;
    if (rd) begin
      mq.delete();
      mpc = rp;
    end else begin
      if (pop) void'(mq.pop_front());
      if (req) begin
        e.pc = mpc;
        e.ins = memf(mpc);
        mq.push_back(e);
        mpc = mpc + 64'd4;
      end
    end
  endtask

  task automatic cyc(bit rdy, bit rd, logic [AW-1:0] rp);
    @(negedge clk);
    ifc.out_ready = rdy;
    ifc.redirect_valid = rd;
    ifc.redirect_pc = rp;
    #1;
    checkAll();
    if (rstn && ifc.out_valid && rdy) acc.push_back(ifc.out_pc);
    @(posedge clk);
    if (rstn) modelStep(rdy, rd, rp);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    mq.delete();
    mpc = '0;
    repeat (2) cyc(1'b0, 1'b0, '0);
    #1 rstn = 1'b1;
  endtask

  int n8;
  int nC;
  int i8;

  initial begin
    ifc.out_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    mpc = '0;

    // Reset fill
    doReset();
    repeat (4) cyc(1'b0, 1'b0, '0);
    #1;
    cmp("fill_count", AW'(ifc.count), 64'd4);
    cmp("fill_req", AW'(ifc.imem_req), 64'd0);
    cmp("fill_addr", ifc.imem_addr, 64'h10);
    cmp("fill_head", ifc.out_pc, 64'h0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);

    // Flush while full
    cyc(1'b0, 1'b1, 64'h100);
    #1;
    cmp("flush_count", AW'(ifc.count), 64'd0);
    cmp("flush_valid", AW'(ifc.out_valid), 64'd0);
    cmp("flush_addr", ifc.imem_addr, 64'h100);
    cyc(1'b1, 1'b0, '0);
    #1;
    cmp("flush_pc0", ifc.out_pc, 64'h100);
    cyc(1'b1, 1'b0, '0);
    #1;
    cmp("flush_pc1", ifc.out_pc, 64'h104);

    // Streaming
    doReset();
    acc.delete();
    cyc(1'b1, 1'b0, '0);
    #1;
    cmp("stream_v2", AW'(ifc.out_valid), 64'd1);
    repeat (9) cyc(1'b1, 1'b0, '0);
    cmp("stream_len", AW'(acc.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < acc.size(); i++)
      cmp("stream_pc", acc[i], 64'(4 * i));
    #1;
    cmp("stream_count", AW'(ifc.count), 64'd1);

    // Redirect with same-cycle handshake on head 0x8
    doReset();
    acc.delete();
    repeat (3) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 64'h200);
    repeat (6) cyc(1'b1, 1'b0, '0);
    n8 = 0;
    nC = 0;
    i8 = -1;
    foreach (acc[i]) begin
      if (acc[i] == 64'h8) begin n8++; i8 = i; end
      if (acc[i] == 64'hC) nC++;
    end
    cmp("hs_once8", AW'(n8), 64'd1);
    cmp("hs_noC", AW'(nC), 64'd0);
    cmp("hs_next", (i8 >= 0 && i8 + 1 < acc.size()) ? acc[i8+1] : '1,
        64'h200);

    // PC wrap-around
    cyc(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    acc.delete();
    repeat (6) cyc(1'b1, 1'b0, '0);
    cmp("wrap_len", AW'(acc.size() >= 4), 64'd1);
    if (acc.size() >= 4) begin
      cmp("wrap0", acc[0], 64'hFFFF_FFFF_FFFF_FFF8);
      cmp("wrap1", acc[1], 64'hFFFF_FFFF_FFFF_FFFC);
      cmp("wrap2", acc[2], 64'h0);
      cmp("wrap3", acc[3], 64'h4);
    end

    // Async reset mid-stream with three entries queued
    doReset();
    repeat (3) cyc(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    cmp("pre_async_count", AW'(ifc.count), 64'd3);
    #1 rstn = 1'b0;
    mq.delete();
    mpc = '0;
    #1;
    cmp("async_valid", AW'(ifc.out_valid), 64'd0);
    cmp("async_count", AW'(ifc.count), 64'd0);
    cmp("async_addr", ifc.imem_addr, 64'h0);
    cmp("async_req", AW'(ifc.imem_req), 64'd0);
    cyc(1'b0, 1'b0, '0);
    #1 rstn = 1'b1;

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      bit rdy;
      bit rd;
      logic [AW-1:0] rp;
      rdy = $urandom_range(0, 9) < 7;
      rd = $urandom_range(0, 24) == 0;
      if ($urandom_range(0, 3) == 0)
        rp = 64'hFFFF_FFFF_FFFF_FFF0;
      else
        rp = {$urandom(), $urandom()} & ~64'h3;
      if ($urandom_range(0, 299) == 0) doReset();
      else cyc(rdy, rd, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nA, nF);
    $finish;
  end
endmodule
